// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU stage types.
// Provides XLEN, the alu_op_e opcode encodings, the alu_state_e FSM states
// and the is_shift() opcode helper.
package cpu_pkg;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;
    function automatic logic is_shift(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_stage_if.sv
// alu_stage_if: operation/result handshake bundle for alu_stage.
// Upstream: valid_i, ready_o, op_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i,
// rd_addr_i, wr_en_i. Downstream: valid_o, ready_i, result_o, rd_addr_o, wr_en_o.
// slave is the stage side, master is the driving (pipeline/testbench) side.
interface alu_stage_if;
    import cpu_pkg::*;
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [XLEN-1:0] imm_i;
    logic            use_imm_i;
    logic [4:0]      rd_addr_i;
    logic            wr_en_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_addr_o;
    logic            wr_en_o;
    modport slave (
        input  valid_i, op_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i, rd_addr_i, wr_en_i, ready_i,
        output ready_o, valid_o, result_o, rd_addr_o, wr_en_o
    );
    modport master (
        output valid_i, op_i, rs1_data_i, rs2_data_i, imm_i, use_imm_i, rd_addr_i, wr_en_i, ready_i,
        input  ready_o, valid_o, result_o, rd_addr_o, wr_en_o
    );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: SLL/SRL/SRA shifter for alu_stage.
// Ports: clk_i, rst_i; load_i starts a shift of a_i by amt_i using op_i;
// res_o is the value after the step taken this cycle, last_o flags that res_o is final.
// ALU_STAGE_FAST_SHIFT_EN defined: single-cycle barrel shifter, last_o always 1.
// Otherwise: one bit per cycle, the load cycle already applying the first bit.
module shift_unit
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [4:0]      amt_i,
    output logic [XLEN-1:0] res_o,
    output logic            last_o
);
`ifdef ALU_STAGE_FAST_SHIFT_EN
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_i, load_i};
    always_comb begin
        res_o = op_i == ALU_SLL ? a_i << amt_i :
                op_i == ALU_SRA ? XLEN'($signed(a_i) >>> amt_i) : a_i >> amt_i;
        last_o = 1'b1;
    end
`else
    logic [3:0]      op_q;
    logic [XLEN-1:0] val_q;
    logic [4:0]      cnt_q;
    logic [3:0]      op;
    logic [XLEN-1:0] src;
    always_comb begin
        op     = load_i ? op_i : op_q;
        src    = load_i ? a_i : val_q;
        res_o  = load_i && amt_i == 5'd0 ? a_i :
                 op == ALU_SLL ? {src[XLEN-2:0], 1'b0} : {op == ALU_SRA && src[XLEN-1], src[XLEN-1:1]};
        last_o = load_i ? amt_i <= 5'd1 : cnt_q == 5'd1;
    end
    // cnt_q counts steps still to apply after the current value in val_q
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q  <= '0;
            val_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            op_q  <= op_i;
            val_q <= res_o;
            cnt_q <= amt_i - {4'b0, |amt_i};
        end else if (cnt_q != 5'd0) begin
            val_q <= res_o;
            cnt_q <= cnt_q - 5'd1;
        end
    end
`endif
endmodule

// File: rtl/alu_stage.sv
// alu_stage: single-operation execute stage with valid/ready on both sides.
// Ports: clk_i, rst_i (sync, active-high), bus (alu_stage_if.slave).
// IDLE accepts, SHIFT iterates long shifts, DONE holds the result until released.
// Macro ALU_STAGE_FAST_SHIFT_EN selects a barrel shifter (all ops 1-cycle latency).
module alu_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_stage_if.slave  bus
);
    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] a, b, alu_res, sh_res, result_q;
    logic [4:0]      rd_q;
    logic            wr_q, accept, shift_op, sh_last;
    assign a        = bus.rs1_data_i;
    assign b        = bus.use_imm_i ? bus.imm_i : bus.rs2_data_i;
    assign accept   = bus.valid_i && state_q == IDLE;
    assign shift_op = is_shift(bus.op_i);
    shift_unit u_shift (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (accept && shift_op),
        .op_i   (bus.op_i),
        .a_i    (a),
        .amt_i  (b[4:0]),
        .res_o  (sh_res),
        .last_o (sh_last)
    );
    always_comb begin
        alu_res = '0;
        case (bus.op_i)
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  alu_res = a ^ b;
            ALU_OR:   alu_res = a | b;
            ALU_AND:  alu_res = a & b;
            default:  alu_res = '0;
        endcase
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && bus.valid_i)
            state_d = shift_op && !sh_last ? SHIFT : DONE;
        else if (state_q == SHIFT && sh_last)
            state_d = DONE;
        else if (state_q == DONE && bus.ready_i)
            state_d = IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q <= bus.rd_addr_i;
                wr_q <= bus.wr_en_i && bus.rd_addr_i != 5'd0 && bus.op_i <= ALU_AND;
            end
            // result only moves when entering DONE, so it is stable while held there
            if (state_d == DONE && state_q != DONE)
                result_q <= state_q == IDLE && !shift_op ? alu_res : sh_res;
        end
    end
    assign bus.ready_o   = state_q == IDLE;
    assign bus.valid_o   = state_q == DONE;
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_q;
    assign bus.wr_en_o   = wr_q;
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: self-checking bench for alu_stage (directed table, random ops, reset sequences).
module tb_alu_stage;
    import cpu_pkg::*;
`ifdef ALU_STAGE_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ui;
        logic [4:0]  rd;
        logic        we;
        int          stall;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[13];

    always #5 clk = ~clk;

    alu_stage_if bus();
    alu_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned k = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << k;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> k;
            4'd7:    return 32'($signed(a) >>> k);
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
        return (!FAST && (op == 4'd2 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0) ? int'(b[4:0]) : 1;
    endfunction

    // Called at a negedge with the stage idle; returns at a negedge with it idle again.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ui, input logic [4:0] rd, input logic we, input int stall,
                         input logic [31:0] exp_res);
        int          lat = 1;
        logic [31:0] r;
        logic [7:0]  ctl;
        bus.valid_i    = 1'b1;
        bus.op_i       = op;
        bus.rs1_data_i = a;
        bus.rs2_data_i = ui ? $urandom : b;
        bus.imm_i      = ui ? b : $urandom;
        bus.use_imm_i  = ui;
        bus.rd_addr_i  = rd;
        bus.wr_en_i    = we;
        bus.ready_i    = stall == 0;
        check({tag, " ready_o idle"}, 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i    = 1'b0;
        bus.op_i       = 4'($urandom);
        bus.rs1_data_i = $urandom;
        bus.rd_addr_i  = 5'($urandom);
        bus.wr_en_i    = 1'b1;
        while (!bus.valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat(op, b)));
        check({tag, " result_o"}, bus.result_o, exp_res);
        check({tag, " rd_addr_o"}, 32'(bus.rd_addr_o), 32'(rd));
        check({tag, " wr_en_o"}, 32'(bus.wr_en_o), 32'(we && rd != 5'd0 && op <= 4'd9));
        r   = bus.result_o;
        ctl = {bus.rd_addr_o, bus.wr_en_o, bus.valid_o, bus.ready_o};
        for (int i = 0; i < stall; i++) begin
            bus.valid_i = 1'b1;
            @(negedge clk);
            check({tag, " held result_o"}, bus.result_o, r);
            check({tag, " held rd/wr/valid/ready"}, 32'({bus.rd_addr_o, bus.wr_en_o, bus.valid_o, bus.ready_o}), 32'(ctl));
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        check({tag, " idle after release"}, 32'({bus.valid_o, bus.ready_o}), 32'b01);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        seen;
        vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'd1,         1'b0, 5'd1,  1'b1, 0, 32'h8000_0000};
        vecs[1]  = '{4'd1,  32'd0,         32'd1,         1'b0, 5'd2,  1'b1, 0, 32'hFFFF_FFFF};
        vecs[2]  = '{4'd3,  32'hFFFF_FFFF, 32'd1,         1'b0, 5'd3,  1'b1, 0, 32'd1};
        vecs[3]  = '{4'd4,  32'hFFFF_FFFF, 32'd1,         1'b0, 5'd4,  1'b1, 0, 32'd0};
        vecs[4]  = '{4'd7,  32'h8000_0000, 32'd4,         1'b1, 5'd5,  1'b1, 0, 32'hF800_0000};
        vecs[5]  = '{4'd6,  32'h8000_0000, 32'd4,         1'b0, 5'd6,  1'b0, 1, 32'h0800_0000};
        vecs[6]  = '{4'd2,  32'd1,         32'd31,        1'b0, 5'd7,  1'b1, 0, 32'h8000_0000};
        vecs[7]  = '{4'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5'd8,  1'b1, 0, 32'h0FF0_0FF0};
        vecs[8]  = '{4'd8,  32'h1234_0000, 32'h0000_5678, 1'b1, 5'd9,  1'b1, 0, 32'h1234_5678};
        vecs[9]  = '{4'd9,  32'hFFFF_0000, 32'h1234_5678, 1'b0, 5'd10, 1'b1, 5, 32'h1234_0000};
        vecs[10] = '{4'd2,  32'd5,         32'h0000_0020, 1'b0, 5'd11, 1'b1, 0, 32'd5};
        vecs[11] = '{4'd12, 32'hDEAD_BEEF, 32'd7,         1'b0, 5'd12, 1'b1, 0, 32'd0};
        vecs[12] = '{4'd0,  32'd1,         32'd2,         1'b0, 5'd0,  1'b1, 0, 32'd3};

        bus.valid_i = 1'b0; bus.op_i = '0; bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.imm_i = '0;
        bus.use_imm_i = 1'b0; bus.rd_addr_i = '0; bus.wr_en_i = 1'b0; bus.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid_o", 32'(bus.valid_o), 32'd0);
        check("reset ready_o", 32'(bus.ready_o), 32'd1);
        check("reset result_o", bus.result_o, 32'd0);
        check("reset rd/wr", 32'({bus.rd_addr_o, bus.wr_en_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ui,
                  vecs[i].rd, vecs[i].we, vecs[i].stall, vecs[i].exp);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            do_op($sformatf("rnd%0d op%0d", i, op), op, a, b, 1'($urandom), 5'($urandom), 1'($urandom),
                  $urandom_range(0, 2), model(op, a, b));
        end

        // reset part-way through a long shift: the op is dropped
        bus.valid_i = 1'b1; bus.op_i = 4'd2; bus.rs1_data_i = 32'd1; bus.rs2_data_i = 32'd31;
        bus.use_imm_i = 1'b0; bus.rd_addr_i = 5'd3; bus.wr_en_i = 1'b1; bus.ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("shift abort valid_o", 32'(bus.valid_o), 32'd0);
        check("shift abort ready_o", 32'(bus.ready_o), 32'd1);
        check("shift abort result_o", bus.result_o, 32'd0);
        check("shift abort wr_en_o", 32'(bus.wr_en_o), 32'd0);
        bus.ready_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.valid_o;
        end
        check("shift abort never delivered", 32'(seen), 32'd0);

        // reset wins over a concurrent release and a concurrent accept
        bus.valid_i = 1'b1; bus.op_i = 4'd0; bus.rs1_data_i = 32'd40; bus.rs2_data_i = 32'd2;
        bus.rd_addr_i = 5'd9; bus.ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("pre-reset done valid_o", 32'(bus.valid_o), 32'd1);
        check("pre-reset done result_o", bus.result_o, 32'd42);
        bus.ready_i = 1'b1; bus.valid_i = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("reset over release result_o", bus.result_o, 32'd0);
        check("reset over release rd_addr_o", 32'(bus.rd_addr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.valid_i = 1'b0;
        check("reset over accept idle", 32'({bus.valid_o, bus.ready_o}), 32'b01);
        @(negedge clk);
        check("reset over accept still idle", 32'({bus.valid_o, bus.ready_o}), 32'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_i  input  1  reset; synchronous, active-high.
REQ-004 Port: valid_i  input  1  upstream (register-file side) has an operation available.
REQ-005 Port: ready_o  output  1  stage can accept an operation.
REQ-006 Port: op_i  input  4  ALU op: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
REQ-007 Port: rs1_data_i  input  XLEN  operand A.
REQ-008 Port: rs2_data_i  input  XLEN  operand B when use_imm_i=0.
REQ-009 Port: imm_i  input  XLEN  sign-extended immediate; operand B when use_imm_i=1.
REQ-010 Port: use_imm_i  input  1  operand-B select.
REQ-011 Port: rd_addr_i  input  5  destination register, passed through.
REQ-012 Port: wr_en_i  input  1  write-back enable, passed through.
REQ-013 Port: valid_o  output  1  result available downstream.
REQ-014 Port: ready_i  input  1  downstream (write-back) can accept the result.
REQ-015 Port: result_o  output  XLEN  ALU result.
REQ-016 Port: rd_addr_o  output  5  registered rd_addr_i.
REQ-017 Port: wr_en_o  output  1  registered wr_en_i; forced 0 when rd_addr_i=0.

Function
REQ-018 FSM states IDLE, SHIFT, DONE; ready_o=1 only in IDLE; valid_o=1 only in DONE.
REQ-019 Accept (valid_i && ready_o): op_i, both operands, rd_addr_i and wr_en_i captured in the same edge; inputs ignored at all other times.
REQ-020 Non-shift op, or shift with amount B[4:0]=0: IDLE->DONE on the accept edge; valid_o high the next cycle (1-cycle latency).
REQ-021 Shift op (SLL/SRL/SRA) with amount k=B[4:0]>0: IDLE->SHIFT; one bit shifted per cycle; SHIFT->DONE on the edge applying bit k; valid_o first high k cycles after accept.
REQ-022 Arithmetic: ADD/SUB mod 2^32; SLT signed and SLTU unsigned compares yield 0 or 1; SRA replicates bit 31; only B[4:0] used for shifts.
REQ-023 Undefined op codes (10-15): result_o=0, wr_en_o=0, 1-cycle latency.
REQ-024 DONE: result_o, rd_addr_o and wr_en_o held stable while valid_o=1 && ready_i=0.
REQ-025 Release (valid_o && ready_i): DONE->IDLE; no accept in the same cycle (ready_o=0 in DONE); sustained throughput 1 op per 2 cycles.
REQ-026 valid_i is ignored in SHIFT and DONE; no buffering of a second op.

Reset
REQ-027 rst_i high at an edge: state=IDLE, valid_o=0, ready_o=1 the next cycle, result_o=0, rd_addr_o=0, wr_en_o=0, shift counter=0.
REQ-028 Reset in SHIFT or DONE aborts the op; no result is delivered for it.
REQ-029 Reset has priority over concurrent accept or release.

Configuration
REQ-030 Macro ALU_STAGE_FAST_SHIFT_EN defined: shifts computed by a single-cycle barrel shifter, all ops 1-cycle latency, SHIFT state unreachable.
REQ-031 Macro ALU_STAGE_FAST_SHIFT_EN undefined: iterative shifter per REQ-021; the barrel shifter is not instantiated.

Structure
REQ-032 Package cpu_pkg holds the alu_op_e enum (REQ-006 encodings), XLEN, and the alu_state_e enum.
REQ-033 Sub-module shift_unit holds the shifter (iterative or barrel per REQ-030/031); alu_stage holds the FSM, the non-shift ALU and the output registers.

Verification
REQ-034 ADD A=0x7FFFFFFF, B=1, ready_i=1 -> valid_o one cycle after accept, result_o=0x80000000.
REQ-035 SRA A=0x80000000, imm=4, use_imm=1 -> result_o=0xF8000000; valid_o 4 cycles after accept (1 with FAST_SHIFT_EN).
REQ-036 SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-037 Result in DONE with ready_i=0 for 5 cycles -> outputs stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next cycle.
REQ-038 SLL A=1, B=31, rst_i pulsed at cycle 10 of SHIFT -> valid_o=0, ready_o=1, result_o=0 after reset; the op is never delivered.
REQ-039 ADD rd_addr_i=0, wr_en_i=1 -> wr_en_o=0; op code 12 -> result_o=0, wr_en_o=0.
